// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C slave byte controller: FSM encoding,
// ACK/NACK bus levels and byte/counter widths.
package i2c_pkg;

    localparam int BYTE_W = 8;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    // bit_cnt holds 0..BYTE_W, so four bits are enough for a byte
    localparam logic [3:0] CNT_LAST = 4'(BYTE_W - 1);
    localparam logic [3:0] CNT_FULL = 4'(BYTE_W);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        RX,
        RX_ACK,
        TX,
        TX_ACK
    } state_e;

endpackage

// File: rtl/i2c_cond_det.sv
// START/STOP detector on the synchronized bus: compares SDA against its
// one-cycle-delayed copy while SCL is high.
module i2c_cond_det (
    input  logic clk_i,
    input  logic rst_i,
    input  logic scl_i,
    input  logic sda_i,
    output logic start_o,
    output logic stop_o
);

    logic sda_q;

    // Reset to the idle-bus level so leaving reset never fakes a STOP.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sda_q <= 1'b1;
        end else begin
            sda_q <= sda_i;
        end
    end

    assign start_o = scl_i &  sda_q & ~sda_i;
    assign stop_o  = scl_i & ~sda_q &  sda_i;

endmodule

// File: rtl/i2c_slave_byte_ctrl.sv
// Byte-level I2C slave: address match, write reception with ACK and read
// transmission with master ACK/NACK, driven by mid-HIGH/mid-LOW SCL strobes.
module i2c_slave_byte_ctrl
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLV_ADDR = 7'h3C
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              I_SCL,
    input  logic              I_SDA,
    input  logic              I_MDL_HG_IO_SCL,
    input  logic              I_MDL_LW_IO_SCL,
    input  logic [BYTE_W-1:0] I_TX_DATA,
    output logic              O_SDA_OE,
    output logic [BYTE_W-1:0] O_RX_DATA,
    output logic              O_RX_VLD,
    output logic              O_TX_REQ,
    output logic              O_RW,
    output logic              O_ADDR_MATCH,
    output logic              O_BUSY,
    output logic              O_START,
    output logic              O_STOP
);

    state_e            state_q, state_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-1:0] shift_q, shift_d;
    logic              ack_ph_q, ack_ph_d;
    logic              sda_oe_q, sda_oe_d;
    logic [BYTE_W-1:0] rx_data_q, rx_data_d;
    logic              rx_vld_q, rx_vld_d;
    logic              tx_req_q, tx_req_d;
    logic              rw_q, rw_d;
    logic              addr_match_q, addr_match_d;
    logic              busy_q, busy_d;
    logic              start_q, start_d;
    logic              stop_q, stop_d;

    logic              start_det;
    logic              stop_det;
    logic              mid_hg;
    logic              mid_lw;
    logic [BYTE_W-1:0] shifted_in;

    i2c_cond_det u_cond_det (
        .clk_i   (CLK),
        .rst_i   (RST),
        .scl_i   (I_SCL),
        .sda_i   (I_SDA),
        .start_o (start_det),
        .stop_o  (stop_det)
    );

    assign mid_hg     = I_MDL_HG_IO_SCL;
    assign mid_lw     = I_MDL_LW_IO_SCL;
    assign shifted_in = {shift_q[BYTE_W-2:0], I_SDA};

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        ack_ph_d     = ack_ph_q;
        sda_oe_d     = sda_oe_q;
        rx_data_d    = rx_data_q;
        rx_vld_d     = 1'b0;
        tx_req_d     = 1'b0;
        rw_d         = rw_q;
        addr_match_d = 1'b0;
        busy_d       = busy_q;
        start_d      = start_det;
        stop_d       = stop_det;

        if (start_det) begin
            state_d   = ADDR;
            bit_cnt_d = '0;
            ack_ph_d  = 1'b0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b1;
        end else if (stop_det) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            ack_ph_d  = 1'b0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                end

                ADDR: begin
                    if (mid_hg) begin
                        shift_d   = shifted_in;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == CNT_LAST) begin
                            if (shifted_in[BYTE_W-1:1] == SLV_ADDR) begin
                                rw_d         = shifted_in[0];
                                addr_match_d = 1'b1;
                                ack_ph_d     = 1'b0;
                                state_d      = ADDR_ACK;
                            end else begin
                                state_d = IDLE;
                            end
                        end
                    end
                end

                // ack_ph_q marks that the ACK is already on the bus; the
                // following mid-LOW starts the data phase.
                ADDR_ACK: begin
                    if (mid_lw) begin
                        if (!ack_ph_q) begin
                            sda_oe_d = 1'b1;
                            ack_ph_d = 1'b1;
                        end else begin
                            ack_ph_d  = 1'b0;
                            bit_cnt_d = '0;
                            if (rw_q) begin
                                shift_d  = I_TX_DATA;
                                sda_oe_d = ~I_TX_DATA[BYTE_W-1];
                                state_d  = TX;
                            end else begin
                                sda_oe_d = 1'b0;
                                state_d  = RX;
                            end
                        end
                    end else if (mid_hg && ack_ph_q && rw_q) begin
                        tx_req_d = 1'b1;
                    end
                end

                RX: begin
                    if (mid_hg) begin
                        shift_d   = shifted_in;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == CNT_LAST) begin
                            rx_data_d = shifted_in;
                            rx_vld_d  = 1'b1;
                            ack_ph_d  = 1'b0;
                            state_d   = RX_ACK;
                        end
                    end
                end

                RX_ACK: begin
                    if (mid_lw) begin
                        if (!ack_ph_q) begin
                            sda_oe_d = 1'b1;
                            ack_ph_d = 1'b1;
                        end else begin
                            sda_oe_d  = 1'b0;
                            ack_ph_d  = 1'b0;
                            bit_cnt_d = '0;
                            state_d   = RX;
                        end
                    end
                end

                // shift_q[MSB] is the bit currently on the bus; bit_cnt
                // counts bits the master has already sampled.
                TX: begin
                    if (mid_lw) begin
                        if (bit_cnt_q == CNT_FULL) begin
                            sda_oe_d = 1'b0;
                            ack_ph_d = 1'b0;
                            state_d  = TX_ACK;
                        end else begin
                            shift_d  = {shift_q[BYTE_W-2:0], 1'b0};
                            sda_oe_d = ~shift_q[BYTE_W-2];
                        end
                    end else if (mid_hg && (bit_cnt_q != CNT_FULL)) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end

                TX_ACK: begin
                    if (mid_hg && !ack_ph_q) begin
                        if (I_SDA == I2C_ACK) begin
                            tx_req_d = 1'b1;
                            ack_ph_d = 1'b1;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = IDLE;
                        end
                    end else if (mid_lw && ack_ph_q) begin
                        shift_d   = I_TX_DATA;
                        sda_oe_d  = ~I_TX_DATA[BYTE_W-1];
                        bit_cnt_d = '0;
                        ack_ph_d  = 1'b0;
                        state_d   = TX;
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            ack_ph_q     <= 1'b0;
            sda_oe_q     <= 1'b0;
            rx_data_q    <= '0;
            rx_vld_q     <= 1'b0;
            tx_req_q     <= 1'b0;
            rw_q         <= 1'b0;
            addr_match_q <= 1'b0;
            busy_q       <= 1'b0;
            start_q      <= 1'b0;
            stop_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            ack_ph_q     <= ack_ph_d;
            sda_oe_q     <= sda_oe_d;
            rx_data_q    <= rx_data_d;
            rx_vld_q     <= rx_vld_d;
            tx_req_q     <= tx_req_d;
            rw_q         <= rw_d;
            addr_match_q <= addr_match_d;
            busy_q       <= busy_d;
            start_q      <= start_d;
            stop_q       <= stop_d;
        end
    end

    assign O_SDA_OE     = sda_oe_q;
    assign O_RX_DATA    = rx_data_q;
    assign O_RX_VLD     = rx_vld_q;
    assign O_TX_REQ     = tx_req_q;
    assign O_RW         = rw_q;
    assign O_ADDR_MATCH = addr_match_q;
    assign O_BUSY       = busy_q;
    assign O_START      = start_q;
    assign O_STOP       = stop_q;

endmodule
